program_loader: RTL and testbench
=================================

# program_loader

Upstream feeder for the single-cycle CPU. It accepts a little-endian byte stream over a valid/ready handshake, packs the bytes into 32-bit instruction words, and writes them sequentially into instruction memory through its write port. Once the last word is written, it asserts `cpu_start` to the CPU's `start` input and holds it, releasing the CPU from reset. A malformed or oversized stream is reported on `err`, and in that case the CPU stays in reset.

## Interface
- `DEPTH`, default 256: instruction-memory capacity in 32-bit words; a power of two, ≥2.
- `CNT_W`, default 9: width of `loaded_words`; must satisfy `CNT_W` ≥ log2(`DEPTH`)+1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte present on `in_byte`.
- `in_byte`  in  8  stream byte.
- `in_last`  in  1  qualifies the final byte of the stream.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of the word being written; always a multiple of 4.
- `imem_wdata`  out  32  word being written.
- `cpu_start`  out  1  drives the CPU `start` input; high means run.
- `err`  out  1  sticky error flag.
- `loaded_words`  out  `CNT_W`  count of words written since reset.

## Operation
- A byte is accepted on any cycle where `in_valid` && `in_ready` are both high. `in_byte` and `in_last` are sampled only on accepted cycles.
- Packing is little-endian. Byte lane k (k = 0..3) goes to `imem_wdata`[8k+7:8k], and the lane counter wraps 3→0.
- States:
  - IDLE (reset state): `in_ready`=1. Accepting a byte moves to LOAD, or straight to WRITE if it is the fourth byte or carries `in_last`.
  - LOAD: `in_ready`=1. Moves to WRITE when lane 3 is accepted or when `in_last` is accepted.
  - WRITE: exactly one cycle. `in_ready`=0, `imem_we`=1, `imem_addr`=`loaded_words`×4. If `in_last` was seen, the next state is RUN; otherwise LOAD.
  - RUN: `cpu_start`=1, `in_ready`=0. Terminal until reset.
  - ERR: `err`=1, `in_ready`=0, `cpu_start`=0. Terminal until reset.
- Partial final word: when `in_last` arrives on lane k < 3, lanes above k are written as 0x00.
- Overflow: a byte accepted while `loaded_words` == `DEPTH` sends the loader to ERR, and no write is issued.
- `in_last` on the very first byte is legal: one word is written, then RUN.
- `loaded_words` increments in the cycle after each WRITE. It never exceeds `DEPTH`.

## Timing
- All outputs are 0 during reset and in the first cycle after `rst` is released. `in_ready` goes to 1 in the cycle after `rst` rises.
- Fourth byte (or `in_last` byte) accepted in cycle N → `imem_we` is high in cycle N+1 → `in_ready` returns to 1 in cycle N+2.
- The final WRITE in cycle M puts `cpu_start` high from cycle M+1 onward. The CPU leaves reset at the edge ending cycle M+1.
- Throughput: at most 4 bytes per 5 cycles.
- When `in_valid` is low, state holds and no lane advances.
- Reset asserted mid-load: discard the partial word, return to IDLE, clear `loaded_words` and `err`, drop `cpu_start` in the same edge. Instruction-memory contents are untouched.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The final complete word of the stream is a checksum and is not written to memory.
  - `in_last` must fall on lane 3; on any other lane the loader goes to ERR.
  - The loader keeps a 32-bit wrap-around sum of all written words.
  - On the checksum word's lane-3 byte, the loader enters a one-cycle CHECK state (`in_ready`=0). A match goes to RUN (`cpu_start` one cycle later than the WRITE→RUN timing above). A mismatch goes to ERR.
  - A stream that is only the checksum word is valid when the checksum is 0.
- `LOADER_CHECKSUM_EN` undefined: no CHECK state, no sum register, and every byte is program data.

## Test plan
- Bytes 13 00 00 00 93 00 10 00, with `in_last` on the 8th byte and `in_valid` held high → `imem_we` pulses with addr 0/data 0x00000013 and addr 4/data 0x00100093; `cpu_start`=1 in the cycle after the second pulse; `loaded_words`=2.
- Bytes 13 00 00 00 AB, with `in_last` on AB → second write at addr 4 with data 0x000000AB; then RUN.
- Same 8 bytes as the first scenario, with `in_valid` low on alternate cycles → identical writes and data, only delayed; no duplicate or dropped bytes.
- `DEPTH`=2, 9 bytes with no `in_last` → two writes; the 9th byte gives `err`=1, `cpu_start` stays 0, `in_ready`=0.
- Reset pulsed after 2 bytes, followed by a fresh 4-byte stream 11 22 33 44 with `in_last` → single write at addr 0 with data 0x44332211; `loaded_words`=1.
- `LOADER_CHECKSUM_EN` defined: word 0x00000013 followed by checksum 13 00 00 00 → RUN. With checksum 14 00 00 00 instead → ERR, and only one `imem_we` pulse occurs.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader uses the slave view: it receives the stream and drives the write port.
interface program_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, in_byte, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_byte, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: packs a little-endian byte stream into 32-bit words, writes
// them sequentially into instruction memory, then raises cpu_start. A stream
// that overflows DEPTH words (or fails the checksum) parks the loader in ERR.
// Optional feature macro: LOADER_CHECKSUM_EN -- the final word of the stream is
// a 32-bit wrap-around checksum of all written words and is not written.
// All outputs are registered and derived from the next state, so the memory
// port and handshake change exactly one cycle after the deciding byte.
module program_loader #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus,
    output logic             cpu_start,
    output logic             err,
    output logic [CNT_W-1:0] loaded_words
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK = 3'd5,
`endif
        ST_ERR   = 3'd4
    } state_t;

    state_t           state_r, state_next_s;
    logic [1:0]       lane_r, lane_next_s;
    logic [31:0]      word_r, word_next_s;
    logic             last_r, last_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             in_ready_r, imem_we_r, cpu_start_r, err_r;
    logic [31:0]      imem_addr_r, imem_wdata_r;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      sum_r;
`endif

    // A byte is taken whenever the registered ready and the upstream valid coincide.
    assign accept_s = bus.in_valid && in_ready_r;

    // Next-state, lane and word-assembly logic.
    always_comb begin
        state_next_s = state_r;
        lane_next_s  = lane_r;
        word_next_s  = word_r;
        last_next_s  = last_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (accept_s) begin
                    if (cnt_r == DEPTH_C) begin
                        state_next_s = ST_ERR;
                    end else begin
                        // Clearing at lane 0 leaves the unused upper lanes of a short final word at 0x00.
                        if (lane_r == 2'd0) begin
                            word_next_s = 32'h0000_0000;
                        end else begin
                            word_next_s = word_r;
                        end
                        word_next_s[{lane_r, 3'b000} +: 8] = bus.in_byte;
                        lane_next_s = lane_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        if (bus.in_last && (lane_r != 2'd3)) begin
                            state_next_s = ST_ERR;
                        end else if (lane_r == 2'd3) begin
                            state_next_s = bus.in_last ? ST_CHECK : ST_WRITE;
                        end else begin
                            state_next_s = ST_LOAD;
                        end
`else
                        if (bus.in_last || (lane_r == 2'd3)) begin
                            state_next_s = ST_WRITE;
                            last_next_s  = bus.in_last;
                            lane_next_s  = 2'd0;
                        end else begin
                            state_next_s = ST_LOAD;
                        end
`endif
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WRITE: begin
                state_next_s = last_r ? ST_RUN : ST_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                state_next_s = (sum_r == word_r) ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN: begin
                state_next_s = ST_RUN;
            end
            ST_ERR: begin
                state_next_s = ST_ERR;
            end
            default: begin
                state_next_s = ST_ERR;
            end
        endcase
    end

    // State, datapath and registered outputs; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            lane_r       <= 2'd0;
            word_r       <= 32'h0000_0000;
            last_r       <= 1'b0;
            cnt_r        <= '0;
            in_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'h0000_0000;
            imem_wdata_r <= 32'h0000_0000;
            cpu_start_r  <= 1'b0;
            err_r        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_r        <= 32'h0000_0000;
`endif
        end else begin
            state_r     <= state_next_s;
            lane_r      <= lane_next_s;
            word_r      <= word_next_s;
            last_r      <= last_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE) || (state_next_s == ST_LOAD);
            imem_we_r   <= (state_next_s == ST_WRITE);
            cpu_start_r <= (state_next_s == ST_RUN);
            err_r       <= (state_next_s == ST_ERR);
            if (state_next_s == ST_WRITE) begin
                imem_addr_r  <= 32'({cnt_r, 2'b00});
                imem_wdata_r <= word_next_s;
            end
            if (state_r == ST_WRITE) begin
                cnt_r <= cnt_r + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                sum_r <= sum_r + imem_wdata_r;
`endif
            end
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign cpu_start      = cpu_start_r;
    assign err            = err_r;
    assign loaded_words   = cnt_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: instance a uses DEPTH=256, instance b
// uses DEPTH=2 for the overflow case. A negedge monitor logs write pulses.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic vld = 1'b0;
    logic [7:0] dat = 8'h00;
    logic lst = 1'b0;
    int total = 0;
    int bad = 0;

    program_loader_if ia ();
    program_loader_if ib ();
    logic       cs_a, er_a, cs_b, er_b;
    logic [8:0] lw_a;
    logic [1:0] lw_b;

    assign ia.in_valid = vld && !sel;
    assign ib.in_valid = vld && sel;
    assign ia.in_byte  = dat;
    assign ib.in_byte  = dat;
    assign ia.in_last  = lst;
    assign ib.in_last  = lst;

    program_loader #(.DEPTH(256), .CNT_W(9)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave),
        .cpu_start(cs_a), .err(er_a), .loaded_words(lw_a));
    program_loader #(.DEPTH(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave),
        .cpu_start(cs_b), .err(er_b), .loaded_words(lw_b));

    always #5 clk = ~clk;

    int cyc = 0;
    int na = 0, nb = 0, start_cyc = -1;
    logic [31:0] wa [0:7];
    logic [31:0] wd [0:7];
    int wc [0:7];

    // Log write pulses and the first cycle cpu_start is seen on instance a.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            na = 0; nb = 0; start_cyc = -1;
        end else begin
            if (ia.imem_we && na < 8) begin
                wa[na] = ia.imem_addr; wd[na] = ia.imem_wdata; wc[na] = cyc; na = na + 1;
            end
            if (ib.imem_we) nb = nb + 1;
            if (cs_a && start_cyc < 0) start_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; vld = 1'b0; lst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Offer one byte and return at the negedge after it was accepted.
    task automatic send(input logic [7:0] b, input bit l);
        int n = 0;
        vld = 1'b1; dat = b; lst = l;
        while (!(sel ? ib.in_ready : ia.in_ready) && n < 20) begin
            @(negedge clk); n++;
        end
        chk("ready_wait", {31'd0, n < 20}, 32'd1);
        @(negedge clk);
        vld = 1'b0; lst = 1'b0;
    endtask

    task automatic send_seq(input logic [63:0] s, input int n, input bit last_end, input bit gap);
        for (int i = 0; i < n; i++) begin
            send(s[8*i +: 8], last_end && (i == n - 1));
            if (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(cs_a || er_a) && n < 50) begin
            @(negedge clk); n++;
        end
        chk("done_wait", {31'd0, n < 50}, 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset values and ready timing after release.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ia.in_ready}, 32'd0);
        chk("rst_we", {31'd0, ia.imem_we}, 32'd0);
        chk("rst_start", {31'd0, cs_a}, 32'd0);
        chk("rst_err", {31'd0, er_a}, 32'd0);
        chk("rst_words", {23'd0, lw_a}, 32'd0);
        rst = 1'b1;
        chk("rel_ready0", {31'd0, ia.in_ready}, 32'd0);
        @(negedge clk);
        chk("rel_ready1", {31'd0, ia.in_ready}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Valid checksum: one program word then its sum.
        send_seq(64'h0000_0013_0000_0013, 8, 1'b1, 1'b0);
        wait_done();
        chk("ck_ok_start", {31'd0, cs_a}, 32'd1);
        chk("ck_ok_err", {31'd0, er_a}, 32'd0);
        chk("ck_ok_nwr", na, 32'd1);
        chk("ck_ok_data", wd[0], 32'h0000_0013);
        do_reset();
        @(negedge clk);
        // Bad checksum.
        send_seq(64'h0000_0014_0000_0013, 8, 1'b1, 1'b0);
        wait_done();
        chk("ck_bad_err", {31'd0, er_a}, 32'd1);
        chk("ck_bad_start", {31'd0, cs_a}, 32'd0);
        chk("ck_bad_nwr", na, 32'd1);
`else
        // Two words, in_valid held high.
        send_seq(64'h0010_0093_0000_0013, 8, 1'b1, 1'b0);
        wait_done();
        chk("s1_nwr", na, 32'd2);
        chk("s1_addr0", wa[0], 32'd0);
        chk("s1_data0", wd[0], 32'h0000_0013);
        chk("s1_addr1", wa[1], 32'd4);
        chk("s1_data1", wd[1], 32'h0010_0093);
        chk("s1_gap", wc[1] - wc[0], 32'd5);
        chk("s1_start_cyc", start_cyc, wc[1] + 1);
        chk("s1_words", {23'd0, lw_a}, 32'd2);
        chk("s1_ready", {31'd0, ia.in_ready}, 32'd0);

        // Partial final word.
        do_reset();
        @(negedge clk);
        send_seq(64'h0000_00AB_0000_0013, 5, 1'b1, 1'b0);
        wait_done();
        chk("s2_nwr", na, 32'd2);
        chk("s2_addr1", wa[1], 32'd4);
        chk("s2_data1", wd[1], 32'h0000_00AB);
        chk("s2_start", {31'd0, cs_a}, 32'd1);

        // in_valid low on alternate cycles.
        do_reset();
        @(negedge clk);
        send_seq(64'h0010_0093_0000_0013, 8, 1'b1, 1'b1);
        wait_done();
        chk("s3_nwr", na, 32'd2);
        chk("s3_data0", wd[0], 32'h0000_0013);
        chk("s3_data1", wd[1], 32'h0010_0093);
        chk("s3_words", {23'd0, lw_a}, 32'd2);

        // Reset mid-load, then a fresh single-word stream.
        do_reset();
        @(negedge clk);
        send_seq(64'h0000_0000_0000_BBAA, 2, 1'b0, 1'b0);
        do_reset();
        chk("s5_words_rst", {23'd0, lw_a}, 32'd0);
        @(negedge clk);
        send_seq(64'h0000_0000_4433_2211, 4, 1'b1, 1'b0);
        wait_done();
        chk("s5_nwr", na, 32'd1);
        chk("s5_addr", wa[0], 32'd0);
        chk("s5_data", wd[0], 32'h4433_2211);
        chk("s5_words", {23'd0, lw_a}, 32'd1);

        // in_last on the very first byte.
        do_reset();
        @(negedge clk);
        send(8'h5A, 1'b1);
        wait_done();
        chk("s6_data", wd[0], 32'h0000_005A);
        chk("s6_start", {31'd0, cs_a}, 32'd1);
`endif

        // Overflow on the DEPTH=2 instance.
        do_reset();
        @(negedge clk);
        sel = 1'b1;
        send_seq(64'h0807_0605_0403_0201, 8, 1'b0, 1'b0);
        send(8'h09, 1'b0);
        @(negedge clk);
        #1;
        chk("ov_nwr", nb, 32'd2);
        chk("ov_err", {31'd0, er_b}, 32'd1);
        chk("ov_start", {31'd0, cs_b}, 32'd0);
        chk("ov_ready", {31'd0, ib.in_ready}, 32'd0);
        chk("ov_words", {30'd0, lw_b}, 32'd2);
        sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
